// File: rtl/clock_reset_seq.sv
// Clock-domain bring-up sequencer: DCM reset pulse, lock wait with retry, staggered domain release.
// Optional retry-limit FAULT state enabled by defining CLKSEQ_FAULT_EN.
module clock_reset_seq #(
  parameter int NUM_DCM       = 2,
  parameter int NUM_DOM       = 3,
  parameter int POWERUP_WAIT  = 16,
  parameter int RST_CYCLES    = 4,
  parameter int LOCK_TIMEOUT  = 65535,
  parameter int STABLE_CYCLES = 1024,
  parameter int STAGGER       = 8,
  parameter int MAX_RETRY     = 7
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [NUM_DCM-1:0] lock_in,
  input  logic [NUM_DCM-1:0] dcm_mask,
  input  logic               restart_req,
  output logic [NUM_DCM-1:0] dcm_reset,
  output logic [NUM_DOM-1:0] dom_reset,
  output logic               all_locked,
  output logic [2:0]         state_out,
  output logic [7:0]         retry_count,
  output logic               fault
);

  localparam int CMAX = POWERUP_WAIT + RST_CYCLES + LOCK_TIMEOUT
                      + STABLE_CYCLES + NUM_DOM * STAGGER;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DCMRST = 3'd1,
    S_WAIT   = 3'd2,
    S_STABLE = 3'd3,
    S_REL    = 3'd4,
    S_RUN    = 3'd5,
    S_FAULT  = 3'd6
  } state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [7:0]         retry_q, retry_d, retry_inc;
  logic [NUM_DCM-1:0] lock_s1_q, lock_s2_q;
  logic [NUM_DCM-1:0] dcm_reset_q, dcm_reset_d;
  logic [NUM_DOM-1:0] dom_reset_q, dom_reset_d;
  logic               all_locked_q, all_locked_d;
  logic               reset_phase;
  logic               lk;

  assign lk        = &(lock_s2_q | ~dcm_mask);
  assign retry_inc = (retry_q == 8'hFF) ? retry_q : retry_q + 8'd1;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      retry_q      <= '0;
      lock_s1_q    <= '0;
      lock_s2_q    <= '0;
      dcm_reset_q  <= '1;
      dom_reset_q  <= '1;
      all_locked_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      retry_q      <= retry_d;
      lock_s1_q    <= lock_in;
      lock_s2_q    <= lock_s1_q;
      dcm_reset_q  <= dcm_reset_d;
      dom_reset_q  <= dom_reset_d;
      all_locked_q <= all_locked_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    retry_d = retry_q;
    case (state_q)
      S_IDLE: begin
        if (cnt_q == CW'(POWERUP_WAIT - 1)) begin
          state_d = S_DCMRST;
          cnt_d   = '0;
        end
      end
      S_DCMRST: begin
        if (cnt_q == CW'(RST_CYCLES - 1)) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end
      end
      S_WAIT: begin
        // the detecting cycle already counts as the first stable one
        if (lk) begin
          state_d = S_STABLE;
          cnt_d   = CW'(1);
        end else if (cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
          state_d = S_DCMRST;
          cnt_d   = '0;
          retry_d = retry_inc;
`ifdef CLKSEQ_FAULT_EN
          if (retry_inc >= 8'(MAX_RETRY)) state_d = S_FAULT;
`endif
        end
      end
      S_STABLE: begin
        if (!lk) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end else if (cnt_q >= CW'(STABLE_CYCLES - 1)) begin
          state_d = S_REL;
          cnt_d   = '0;
        end
      end
      S_REL: begin
        if (!lk) begin
          state_d = S_DCMRST;
          cnt_d   = '0;
          retry_d = retry_inc;
        end else if (cnt_q == CW'((NUM_DOM - 1) * STAGGER)) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        cnt_d = '0;
        if (!lk) begin
          state_d = S_DCMRST;
          retry_d = retry_inc;
        end
      end
      S_FAULT: cnt_d = '0;
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
    if (restart_req && state_q != S_IDLE) begin
      state_d = S_DCMRST;
      cnt_d   = '0;
      retry_d = retry_q;
`ifdef CLKSEQ_FAULT_EN
      if (state_q == S_FAULT) retry_d = '0;
`endif
    end
  end

  always_comb begin
    reset_phase  = (state_d == S_IDLE) || (state_d == S_DCMRST)
                || (state_d == S_FAULT);
    dcm_reset_d  = reset_phase ? '1 : ~dcm_mask;
    all_locked_d = (state_d == S_REL) || (state_d == S_RUN);
    for (int i = 0; i < NUM_DOM; i++) begin
      dom_reset_d[i] = !((state_d == S_RUN) ||
                         ((state_d == S_REL) && (cnt_d >= CW'(i * STAGGER))));
    end
  end

`ifdef CLKSEQ_FAULT_EN
  logic fault_q;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) fault_q <= 1'b0;
    else          fault_q <= (state_d == S_FAULT);
  end
  assign fault = fault_q;
`else
  assign fault = 1'b0;
`endif

  assign dcm_reset   = dcm_reset_q;
  assign dom_reset   = dom_reset_q;
  assign all_locked  = all_locked_q;
  assign state_out   = state_q;
  assign retry_count = retry_q;

endmodule

// File: tb/tb_clock_reset_seq.sv
// Directed bench for clock_reset_seq: timeline vector table plus hand-written corner sequences.
// Fault-state expectations apply when CLKSEQ_FAULT_EN is defined.
module tb_clock_reset_seq;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] lock_in = 2'b00;
  logic [1:0] dcm_mask = 2'b11;
  logic       restart_req = 1'b0;
  logic [1:0] dcm_reset;
  logic [2:0] dom_reset;
  logic       all_locked;
  logic [2:0] state_out;
  logic [7:0] retry_count;
  logic       fault;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  typedef struct {
    int         cyc;
    logic [1:0] lock;
    logic [1:0] mask;
    logic       rst;
    logic [2:0] st;
    logic [1:0] dcm;
    logic [2:0] dom;
    logic       al;
    logic [7:0] rt;
  } vec_t;

  vec_t tbl[$];

  clock_reset_seq #(
    .NUM_DCM(2), .NUM_DOM(3), .POWERUP_WAIT(16), .RST_CYCLES(4),
    .LOCK_TIMEOUT(100), .STABLE_CYCLES(20), .STAGGER(8), .MAX_RETRY(2)
  ) dut (
    .clock(clock), .reset_n(reset_n), .lock_in(lock_in),
    .dcm_mask(dcm_mask), .restart_req(restart_req),
    .dcm_reset(dcm_reset), .dom_reset(dom_reset),
    .all_locked(all_locked), .state_out(state_out),
    .retry_count(retry_count), .fault(fault)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [2:0] st,
                         input logic [1:0] dcm, input logic [2:0] dom,
                         input logic al, input logic [7:0] rt);
    chk({tag, ".state"}, 32'(state_out), 32'(st));
    chk({tag, ".dcm"}, 32'(dcm_reset), 32'(dcm));
    chk({tag, ".dom"}, 32'(dom_reset), 32'(dom));
    chk({tag, ".alk"}, 32'(all_locked), 32'(al));
    chk({tag, ".retry"}, 32'(retry_count), 32'(rt));
    chk({tag, ".fault"}, 32'(fault), 32'(st == 3'd6));
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
    cyc++;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) step();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    restart_req = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    cyc = 0;
  endtask

  initial begin
    // cyc, lock, mask, restart | state, dcm, dom, all_locked, retry
    tbl.push_back(vec_t'{  0, 2'b00, 2'b11, 1'b0, 3'd0, 2'b11, 3'b111, 1'b0, 8'd0});
    tbl.push_back(vec_t'{ 15, 2'b00, 2'b11, 1'b0, 3'd0, 2'b11, 3'b111, 1'b0, 8'd0});
    tbl.push_back(vec_t'{ 16, 2'b00, 2'b11, 1'b0, 3'd1, 2'b11, 3'b111, 1'b0, 8'd0});
    tbl.push_back(vec_t'{ 19, 2'b00, 2'b11, 1'b0, 3'd1, 2'b11, 3'b111, 1'b0, 8'd0});
    tbl.push_back(vec_t'{ 20, 2'b00, 2'b11, 1'b0, 3'd2, 2'b00, 3'b111, 1'b0, 8'd0});
    tbl.push_back(vec_t'{ 30, 2'b11, 2'b11, 1'b0, 3'd2, 2'b00, 3'b111, 1'b0, 8'd0});
    tbl.push_back(vec_t'{ 32, 2'b11, 2'b11, 1'b0, 3'd2, 2'b00, 3'b111, 1'b0, 8'd0});
    tbl.push_back(vec_t'{ 33, 2'b11, 2'b11, 1'b0, 3'd3, 2'b00, 3'b111, 1'b0, 8'd0});
    tbl.push_back(vec_t'{ 51, 2'b11, 2'b11, 1'b0, 3'd3, 2'b00, 3'b111, 1'b0, 8'd0});
    tbl.push_back(vec_t'{ 52, 2'b11, 2'b11, 1'b0, 3'd4, 2'b00, 3'b110, 1'b1, 8'd0});
    tbl.push_back(vec_t'{ 59, 2'b11, 2'b11, 1'b0, 3'd4, 2'b00, 3'b110, 1'b1, 8'd0});
    tbl.push_back(vec_t'{ 60, 2'b11, 2'b11, 1'b0, 3'd4, 2'b00, 3'b100, 1'b1, 8'd0});
    tbl.push_back(vec_t'{ 68, 2'b11, 2'b11, 1'b0, 3'd4, 2'b00, 3'b000, 1'b1, 8'd0});
    tbl.push_back(vec_t'{ 69, 2'b11, 2'b11, 1'b0, 3'd5, 2'b00, 3'b000, 1'b1, 8'd0});
    tbl.push_back(vec_t'{ 80, 2'b10, 2'b11, 1'b0, 3'd5, 2'b00, 3'b000, 1'b1, 8'd0});
    tbl.push_back(vec_t'{ 82, 2'b10, 2'b11, 1'b0, 3'd5, 2'b00, 3'b000, 1'b1, 8'd0});
    tbl.push_back(vec_t'{ 83, 2'b10, 2'b11, 1'b0, 3'd1, 2'b11, 3'b111, 1'b0, 8'd1});
    tbl.push_back(vec_t'{ 87, 2'b10, 2'b11, 1'b0, 3'd2, 2'b00, 3'b111, 1'b0, 8'd1});
    tbl.push_back(vec_t'{ 90, 2'b11, 2'b11, 1'b0, 3'd2, 2'b00, 3'b111, 1'b0, 8'd1});
    tbl.push_back(vec_t'{112, 2'b11, 2'b11, 1'b0, 3'd4, 2'b00, 3'b110, 1'b1, 8'd1});
    tbl.push_back(vec_t'{120, 2'b11, 2'b11, 1'b0, 3'd4, 2'b00, 3'b100, 1'b1, 8'd1});
    tbl.push_back(vec_t'{128, 2'b11, 2'b11, 1'b0, 3'd4, 2'b00, 3'b000, 1'b1, 8'd1});
    tbl.push_back(vec_t'{129, 2'b11, 2'b11, 1'b0, 3'd5, 2'b00, 3'b000, 1'b1, 8'd1});
    tbl.push_back(vec_t'{140, 2'b01, 2'b01, 1'b0, 3'd5, 2'b00, 3'b000, 1'b1, 8'd1});
    tbl.push_back(vec_t'{141, 2'b01, 2'b01, 1'b0, 3'd5, 2'b10, 3'b000, 1'b1, 8'd1});
    tbl.push_back(vec_t'{150, 2'b01, 2'b01, 1'b1, 3'd5, 2'b10, 3'b000, 1'b1, 8'd1});
    tbl.push_back(vec_t'{151, 2'b01, 2'b01, 1'b0, 3'd1, 2'b11, 3'b111, 1'b0, 8'd1});
    tbl.push_back(vec_t'{155, 2'b01, 2'b01, 1'b0, 3'd2, 2'b10, 3'b111, 1'b0, 8'd1});
    tbl.push_back(vec_t'{156, 2'b01, 2'b01, 1'b0, 3'd3, 2'b10, 3'b111, 1'b0, 8'd1});
    tbl.push_back(vec_t'{175, 2'b01, 2'b01, 1'b0, 3'd4, 2'b10, 3'b110, 1'b1, 8'd1});
    tbl.push_back(vec_t'{191, 2'b01, 2'b01, 1'b0, 3'd4, 2'b10, 3'b000, 1'b1, 8'd1});
    tbl.push_back(vec_t'{192, 2'b01, 2'b01, 1'b0, 3'd5, 2'b10, 3'b000, 1'b1, 8'd1});

    lock_in = 2'b00;
    dcm_mask = 2'b11;
    do_reset();
    foreach (tbl[i]) begin
      run_to(tbl[i].cyc);
      chk_all($sformatf("v%0d", i), tbl[i].st, tbl[i].dcm, tbl[i].dom,
              tbl[i].al, tbl[i].rt);
      lock_in = tbl[i].lock;
      dcm_mask = tbl[i].mask;
      restart_req = tbl[i].rst;
    end

    // asynchronous reset mid-RUN, between clock edges
    run_to(200);
    #2 reset_n = 1'b0;
    #1 chk_all("async_rst", 3'd0, 2'b11, 3'b111, 1'b0, 8'd0);

    // single-cycle lock glitch while STABLE
    dcm_mask = 2'b11;
    lock_in = 2'b11;
    do_reset();
    run_to(20); chk_all("g20", 3'd2, 2'b00, 3'b111, 1'b0, 8'd0);
    run_to(21); chk_all("g21", 3'd3, 2'b00, 3'b111, 1'b0, 8'd0);
    run_to(30); lock_in = 2'b01;
    run_to(31); lock_in = 2'b11;
    run_to(32); chk_all("g32", 3'd3, 2'b00, 3'b111, 1'b0, 8'd0);
    run_to(33); chk_all("g33", 3'd2, 2'b00, 3'b111, 1'b0, 8'd0);
    run_to(34); chk_all("g34", 3'd3, 2'b00, 3'b111, 1'b0, 8'd0);
    run_to(40); chk_all("g40", 3'd3, 2'b00, 3'b111, 1'b0, 8'd0);
    run_to(52); chk_all("g52", 3'd3, 2'b00, 3'b111, 1'b0, 8'd0);
    run_to(53); chk_all("g53", 3'd4, 2'b00, 3'b110, 1'b1, 8'd0);

    // timeout / retry, restart ignored in IDLE_WAIT
    lock_in = 2'b00;
    do_reset();
    run_to(5); restart_req = 1'b1;
    run_to(6); restart_req = 1'b0;
    chk_all("t6", 3'd0, 2'b11, 3'b111, 1'b0, 8'd0);
    run_to(16);  chk_all("t16", 3'd1, 2'b11, 3'b111, 1'b0, 8'd0);
    run_to(119); chk_all("t119", 3'd2, 2'b00, 3'b111, 1'b0, 8'd0);
    run_to(120); chk_all("t120", 3'd1, 2'b11, 3'b111, 1'b0, 8'd1);
    run_to(123); chk_all("t123", 3'd1, 2'b11, 3'b111, 1'b0, 8'd1);
    run_to(124); chk_all("t124", 3'd2, 2'b00, 3'b111, 1'b0, 8'd1);
    run_to(223); chk_all("t223", 3'd2, 2'b00, 3'b111, 1'b0, 8'd1);
    run_to(224);
`ifdef CLKSEQ_FAULT_EN
    chk_all("t224", 3'd6, 2'b11, 3'b111, 1'b0, 8'd2);
    run_to(230); chk_all("t230", 3'd6, 2'b11, 3'b111, 1'b0, 8'd2);
    restart_req = 1'b1;
    run_to(231); restart_req = 1'b0;
    chk_all("t231", 3'd1, 2'b11, 3'b111, 1'b0, 8'd0);
`else
    chk_all("t224", 3'd1, 2'b11, 3'b111, 1'b0, 8'd2);
    run_to(230); chk_all("t230", 3'd2, 2'b00, 3'b111, 1'b0, 8'd2);
    restart_req = 1'b1;
    run_to(231); restart_req = 1'b0;
    chk_all("t231", 3'd1, 2'b11, 3'b111, 1'b0, 8'd2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/clock_reset_seq.md
Name: clock_reset_seq

Overview:
Parametrised clock-domain bring-up sequencer for NUM_DCM clock managers. Holds the DCMs in reset after configuration, pulses their resets, and waits for every enabled lock with a timeout and retry. Once locks have been stable for a set period, it releases NUM_DOM downstream synchronous resets in staggered order. On lock loss it drops all domains back into reset and restarts automatically.

Parameters:
NUM_DCM, 2, number of DCM lock/reset channels (1..8)
NUM_DOM, 3, number of downstream domain resets (1..8)
POWERUP_WAIT, 16, cycles after reset_n deassert before the first DCM reset pulse
RST_CYCLES, 4, DCM reset pulse width in cycles (>=3)
LOCK_TIMEOUT, 65535, WAIT_LOCK cycles before retry
STABLE_CYCLES, 1024, consecutive all-locked cycles required before release
STAGGER, 8, cycles between successive domain reset releases
MAX_RETRY, 7, timeouts allowed before FAULT (feature only)

Ports:
clock  in  1  sequencer clock (free-running reference, not DCM-derived)
reset_n  in  1  asynchronous active-low reset
lock_in  in  NUM_DCM  DCM LOCKED outputs, asynchronous
dcm_mask  in  NUM_DCM  1 = channel participates; masked channels treated as locked; quasi-static
restart_req  in  1  synchronous single-cycle request to re-run the sequence
dcm_reset  out  NUM_DCM  active-high DCM RST; masked channels held at 1
dom_reset  out  NUM_DOM  active-high synchronous domain resets
all_locked  out  1  high in RELEASE and RUN
state_out  out  3  current state encoding
retry_count  out  8  saturating count of timeouts and lock losses
fault  out  1  retry limit exceeded (feature only; otherwise 0)

Behaviour:
- Reset values (async, reset_n=0): dcm_reset all 1, dom_reset all 1, all_locked 0, retry_count 0, fault 0, state IDLE_WAIT (0), counters 0.
- lock_in passes through a 2-flop synchroniser. lk = &(lock_sync | ~dcm_mask).
- IDLE_WAIT (0): dcm_reset=1. After POWERUP_WAIT cycles -> DCM_RST.
- DCM_RST (1): dcm_reset=1 for exactly RST_CYCLES cycles -> WAIT_LOCK. Unmasked dcm_reset bits go 0 on entry to WAIT_LOCK.
- WAIT_LOCK (2): lk=1 -> STABLE. Counter reaching LOCK_TIMEOUT without lk -> retry_count+1 -> DCM_RST.
- STABLE (3): counts consecutive lk=1 cycles. lk=0 at any point -> WAIT_LOCK with the timeout counter cleared. Count reaching STABLE_CYCLES -> RELEASE.
- RELEASE (4): all_locked=1. dom_reset[i] deasserts at RELEASE-relative cycle i*STAGGER, with dom_reset[0] low in the first RELEASE cycle. After dom_reset[NUM_DOM-1] is released -> RUN.
- RUN (5): holds steady state. lk=0 -> in the same registered cycle, all dom_reset=1 and all_locked=0, retry_count+1 -> DCM_RST. Latency from lock_in falling to dom_reset rising is 3 clock edges.
- Lock loss during RELEASE is handled as in RUN; domains already released reassert.
- restart_req in any state except IDLE_WAIT -> DCM_RST. All dom_reset=1 and all_locked=0. retry_count is not incremented. restart_req has priority over same-cycle lock/timeout events.
- retry_count saturates at 255.
- State encoding: 0 IDLE_WAIT, 1 DCM_RST, 2 WAIT_LOCK, 3 STABLE, 4 RELEASE, 5 RUN, 6 FAULT.
- Mask changes take effect via lk on the next cycle. A masked channel's dcm_reset goes to 1 next cycle.
- reset_n asserted mid-sequence returns all outputs to their reset values immediately (asynchronous).

Optional Feature:
Macro CLKSEQ_FAULT_EN.
- With the macro: a WAIT_LOCK timeout that brings retry_count to MAX_RETRY -> FAULT (6). FAULT holds dcm_reset=1, dom_reset=1, all_locked=0, fault=1. The only exits are restart_req (clears retry_count and fault, -> DCM_RST) or reset_n.
- Without the macro: FAULT is unreachable, fault is tied 0, and retries are unlimited.

Test Plan:
- Bench parameters for all cases: POWERUP_WAIT=16, RST_CYCLES=4, LOCK_TIMEOUT=100, STABLE_CYCLES=20, STAGGER=8, NUM_DOM=3, dcm_mask=2'b11.
- Bring-up: release reset_n, lock_in=2'b11 from cycle 30 -> dcm_reset high cycles 16..19, low at 20. all_locked rises 20 cycles after lk. dom_reset[0..2] fall 0, 8, 16 cycles later. state_out=5.
- Lock glitch in STABLE: lock_in[1] low for 1 cycle at STABLE count 10 -> state returns to 2, then STABLE count restarts; no domain released early.
- Timeout/retry: lock_in[0] stuck 0 -> after 100 WAIT_LOCK cycles retry_count=1 and dcm_reset pulses 4 cycles; repeats each attempt.
- Lock loss in RUN: drop lock_in[0] -> all dom_reset=1 and all_locked=0 exactly 3 edges later, retry_count+1, state 1. Relock -> full staggered release repeats.
- Mask/restart: dcm_mask=2'b01 with lock_in[1]=0 -> reaches RUN, dcm_reset[1]=1. restart_req pulse in RUN -> state 1 next cycle, retry_count unchanged.
- Fault (CLKSEQ_FAULT_EN, MAX_RETRY=2): locks stuck 0 -> after 2 timeouts state=6, fault=1. restart_req -> retry_count=0, fault=0, state 1.
